// File: rtl/fp6_lane_packer_if.sv
// Stream-in / vector-out bus of the FP6 lane packer.
// master drives elements and consumes vectors; slave is the packer.
interface fp6_lane_packer_if #(
    parameter int BETA   = 8,
    parameter int ELEM_W = 6,
    parameter int CNT_W  = $clog2(BETA + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ELEM_W-1:0]        in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [BETA*ELEM_W-1:0]   out_data;
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fp6_lane_packer.sv
// Serial-to-parallel packer: FP6 elements in, zero-padded BETA-lane vectors out.
// Optional FP6_PACKER_NEGZERO_FLUSH_EN stores negative zero as all-zeros.
module fp6_lane_packer #(
    parameter int BETA   = 8,
    parameter int ELEM_W = 6,
    parameter int CNT_W  = $clog2(BETA + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fp6_lane_packer_if.slave  bus
);
    localparam int IDX_W = $clog2(BETA);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_PEND
    } state_t;

    state_t                        state;
    state_t                        state_nx;
    logic [IDX_W-1:0]              idx;
    logic [BETA-1:0][ELEM_W-1:0]   lane_buf;
    logic [BETA-1:0][ELEM_W-1:0]   fill_vec;
    logic [BETA-1:0][ELEM_W-1:0]   out_vec;
    logic [CNT_W-1:0]              pend_count;
    logic [CNT_W-1:0]              out_count_q;
    logic [CNT_W-1:0]              done_count;
    logic                          out_valid_q;
    logic [ELEM_W-1:0]             elem;
    logic                          accept;
    logic                          complete;
    logic                          slot_free;
    logic                          load_direct;
    logic                          load_pend;

    assign bus.in_ready  = (state != S_PEND) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_vec;
    assign bus.out_count = out_count_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign complete    = accept && ((idx == IDX_W'(BETA - 1)) || bus.in_last);
    assign slot_free   = !out_valid_q || bus.out_ready;
    assign load_direct = complete && slot_free;
    assign load_pend   = (state == S_PEND) && out_valid_q && bus.out_ready;
    assign done_count  = CNT_W'(idx) + CNT_W'(1);

    always_comb begin
        elem = bus.in_data;
`ifdef FP6_PACKER_NEGZERO_FLUSH_EN
        if (bus.in_data == {1'b1, {(ELEM_W-1){1'b0}}})
            elem = '0;
`endif
    end

    // Completed vector as it would look after this edge: lanes past idx zero-padded.
    always_comb begin
        fill_vec = '0;
        for (int i = 0; i < BETA; i++) begin
            if (i < int'(idx))
                fill_vec[i] = lane_buf[i];
            else if (i == int'(idx))
                fill_vec[i] = elem;
            else
                fill_vec[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: begin
                if (complete)
                    state_nx = slot_free ? S_EMPTY : S_PEND;
                else if (accept)
                    state_nx = S_FILL;
            end
            S_FILL: begin
                if (complete)
                    state_nx = slot_free ? S_EMPTY : S_PEND;
            end
            S_PEND: begin
                if (load_pend)
                    state_nx = S_EMPTY;
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    // A vector that cannot be presented is parked, padded, in the fill buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            lane_buf   <= '0;
            pend_count <= '0;
        end else if (accept) begin
            if (complete) begin
                idx <= '0;
                if (!slot_free) begin
                    lane_buf   <= fill_vec;
                    pend_count <= done_count;
                end
            end else begin
                lane_buf[idx] <= elem;
                idx           <= idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vec     <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else if (load_direct) begin
            out_vec     <= fill_vec;
            out_count_q <= done_count;
            out_valid_q <= 1'b1;
        end else if (load_pend) begin
            out_vec     <= lane_buf;
            out_count_q <= pend_count;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp6_lane_packer.sv
// Scoreboard bench for fp6_lane_packer: a queue-based model predicts each vector,
// a negedge monitor compares whatever the DUT presents.
module tb_fp6_lane_packer;
    localparam int BETA   = 8;
    localparam int ELEM_W = 6;
    localparam int CNT_W  = $clog2(BETA + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp6_lane_packer_if #(.BETA(BETA), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) bus ();

    fp6_lane_packer #(.BETA(BETA), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  check_count   = 0;
    int  pass_count    = 0;
    int  pop_count     = 0;
    bit  rand_ready_en = 1'b0;

    logic [BETA*ELEM_W-1:0] exp_data_q[$];
    logic [CNT_W-1:0]       exp_count_q[$];
    logic [ELEM_W-1:0]      partial[$];

`ifdef FP6_PACKER_NEGZERO_FLUSH_EN
    localparam logic [ELEM_W-1:0] NZ_EXP = 6'h00;
`else
    localparam logic [ELEM_W-1:0] NZ_EXP = 6'h20;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [ELEM_W-1:0] modelStore(input logic [ELEM_W-1:0] d);
`ifdef FP6_PACKER_NEGZERO_FLUSH_EN
        return (d == 6'h20) ? 6'h00 : d;
`else
        return d;
`endif
    endfunction

    // Reference: gather elements, emit a padded vector on BETA elements or last.
    task automatic modelAccept(input logic [ELEM_W-1:0] d, input logic l);
        logic [BETA*ELEM_W-1:0] vec;
        partial.push_back(modelStore(d));
        if (partial.size() == BETA || l) begin
            vec = '0;
            foreach (partial[i]) vec[i*ELEM_W +: ELEM_W] = partial[i];
            exp_data_q.push_back(vec);
            exp_count_q.push_back(CNT_W'(partial.size()));
            partial.delete();
        end
    endtask

    task automatic applyStimulus(input logic [ELEM_W-1:0] d, input logic l, output int waited);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        waited = 0;
        acc    = 1'b0;
        forever begin
            if (rand_ready_en)
                bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check_count++;
                $display("[TB] FAIL accept_timeout: got no acceptance after %0d cycles, expected acceptance", waited);
                break;
            end
        end
        if (acc)
            modelAccept(d, l);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every presented vector must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_data_q.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_vector: got data 0x%0h, expected no vector", bus.out_data);
            end else begin
                checkOutput("out_data", 64'(bus.out_data), 64'(exp_data_q[0]));
                checkOutput("out_count", 64'(bus.out_count), 64'(exp_count_q[0]));
                if (bus.out_ready) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_count_q.pop_front());
                    pop_count++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int stalls;
        int pops_before;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #2;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_out_count", 64'(bus.out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] full vector 0x01..0x08");
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++)
            applyStimulus(ELEM_W'(i), i == 8, w);
        checkOutput("full_latency", 64'(bus.out_valid), 64'd1);
        idle(1);
        checkOutput("full_one_cycle", 64'(bus.out_valid), 64'd0);

        $display("[TB] short vector via in_last");
        for (int i = 0; i < 3; i++)
            applyStimulus(ELEM_W'(6'h11 + i), i == 2, w);
        idle(2);

        $display("[TB] stalled output, 16 elements");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            applyStimulus(ELEM_W'($urandom_range(0, 63)), 1'b0, w);
        checkOutput("pend_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("pend_out_valid", 64'(bus.out_valid), 64'd1);
        idle(3);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pend_release_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("pend_second_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("pend_drained", 64'(bus.out_valid), 64'd0);

        $display("[TB] continuous streaming, 4 vectors");
        stalls      = 0;
        pops_before = pop_count;
        for (int i = 0; i < 4 * BETA; i++) begin
            applyStimulus(ELEM_W'($urandom_range(0, 63)), 1'b0, w);
            stalls += w;
        end
        idle(2);
        checkOutput("stream_stalls", 64'(stalls), 64'd0);
        checkOutput("stream_vectors", 64'(pop_count - pops_before), 64'd4);

        $display("[TB] reset mid-vector");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(ELEM_W'($urandom_range(1, 63)), i == 2, w);
        for (int i = 0; i < 5; i++)
            applyStimulus(ELEM_W'($urandom_range(1, 63)), 1'b0, w);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("async_out_count", 64'(bus.out_count), 64'd0);
        checkOutput("async_in_ready", 64'(bus.in_ready), 64'd0);
        exp_data_q.delete();
        exp_count_q.delete();
        partial.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rerelease_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < BETA; i++)
            applyStimulus(ELEM_W'($urandom_range(0, 63)), 1'b0, w);
        idle(2);

        $display("[TB] negative zero on lane 0");
        applyStimulus(6'h20, 1'b1, w);
        checkOutput("negzero_lane0", 64'(bus.out_data[ELEM_W-1:0]), 64'(NZ_EXP));
        checkOutput("negzero_count", 64'(bus.out_count), 64'd1);
        idle(2);

        $display("[TB] randomized traffic");
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [ELEM_W-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? 6'h20 : ELEM_W'($urandom_range(0, 63));
            applyStimulus(d, $urandom_range(0, 9) == 0, w);
            if ($urandom_range(0, 5) == 0)
                idle($urandom_range(1, 3));
        end
        applyStimulus(ELEM_W'($urandom_range(0, 63)), 1'b1, w);
        rand_ready_en = 1'b0;

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        n = 0;
        while (exp_data_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(2);
        checkOutput("drain_empty", 64'(exp_data_q.size()), 64'd0);
        checkOutput("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
